// File: rtl/glitcbus_master.sv
// GLITCBUS initiator: serialises one 16-bit-address / 32-bit-data request onto the
// 8-bit multiplexed bus (2 address beats, 2 turnaround beats on reads, 4 data beats).
module glitcbus_master (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] gb_adr_i,
  input  logic [31:0] gb_dat_i,
  input  logic        gb_wr_i,
  input  logic        gb_rd_i,
  output logic [31:0] gb_dat_o,
  output logic        gb_ack_o,
  output logic        gb_busy_o,
  output logic        GSEL_B,
  output logic        GRDWR_B,
  input  logic [7:0]  GAD_i,
  output logic [7:0]  GAD_o,
  output logic        GAD_oe_o
);

  typedef enum logic [2:0] {IDLE, A1, A0, WD, TA, RD, END} state_t;

  state_t      state;
  logic [15:0] adr;
  logic [31:0] sh;
  logic        rd;
  logic [1:0]  cnt;

  assign gb_busy_o = (state != IDLE);

  // Bus pins are computed for the state being entered, so every pin is a flop output.
  // sh holds outgoing write data, then collects incoming read bytes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      adr      <= '0;
      sh       <= '0;
      rd       <= 1'b0;
      cnt      <= '0;
      gb_dat_o <= '0;
      gb_ack_o <= 1'b0;
      GSEL_B   <= 1'b1;
      GRDWR_B  <= 1'b1;
      GAD_o    <= '0;
      GAD_oe_o <= 1'b0;
    end else begin
      gb_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gb_wr_i || gb_rd_i) begin
            state    <= A1;
            adr      <= gb_adr_i;
            sh       <= gb_dat_i;
            rd       <= ~gb_wr_i;
            GSEL_B   <= 1'b0;
            GRDWR_B  <= ~gb_wr_i;
            GAD_o    <= gb_adr_i[15:8];
            GAD_oe_o <= 1'b1;
          end
        end
        A1: begin
          state <= A0;
          GAD_o <= adr[7:0];
        end
        A0: begin
          if (rd) begin
            state    <= TA;
            cnt      <= 2'd1;
            GAD_o    <= '0;
            GAD_oe_o <= 1'b0;
          end else begin
            state <= WD;
            cnt   <= 2'd3;
            GAD_o <= sh[31:24];
            sh    <= {sh[23:0], 8'h00};
          end
        end
        WD: begin
          if (cnt == 2'd0) begin
            state    <= END;
            gb_ack_o <= 1'b1;
            GSEL_B   <= 1'b1;
            GAD_o    <= '0;
            GAD_oe_o <= 1'b0;
          end else begin
            cnt   <= cnt - 2'd1;
            GAD_o <= sh[31:24];
            sh    <= {sh[23:0], 8'h00};
          end
        end
        TA: begin
          if (cnt == 2'd0) begin
            state <= RD;
            cnt   <= 2'd3;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RD: begin
          sh <= {sh[23:0], GAD_i};
          if (cnt == 2'd0) begin
            state    <= END;
            gb_dat_o <= {sh[23:0], GAD_i};
            gb_ack_o <= 1'b1;
            GSEL_B   <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        END: begin
          state   <= IDLE;
          GRDWR_B <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glitcbus_master.sv
// Bench for glitcbus_master: per-cycle vector table, hand-written corner sequences,
// and a randomised write/readback run against a small GLITC slave model.
module tb_glitcbus_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr, rd;
  logic [15:0] adr;
  logic [31:0] wdat, dat_o;
  logic        ack, busy, gsel, grdwr, oe;
  logic [7:0]  gad_in, gad_out, tb_gad;
  logic [7:0]  slave_gad = 8'h00;
  logic        slave_drv = 1'b0;
  logic        slave_en  = 1'b0;

  assign gad_in = slave_drv ? slave_gad : tb_gad;

  glitcbus_master dut (
    .clk_i(clk), .rst_i(rst), .gb_adr_i(adr), .gb_dat_i(wdat),
    .gb_wr_i(wr), .gb_rd_i(rd), .gb_dat_o(dat_o), .gb_ack_o(ack),
    .gb_busy_o(busy), .GSEL_B(gsel), .GRDWR_B(grdwr),
    .GAD_i(gad_in), .GAD_o(gad_out), .GAD_oe_o(oe)
  );

  int passed = 0;
  int total  = 0;
  int viol   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Slave model: tracks beats while GSEL_B is low, stores writes, returns reads in RD beats.
  int          beat = 0;
  logic        s_rd;
  logic [15:0] s_adr;
  logic [31:0] s_data, s_wd;
  logic [31:0] mem [logic [15:0]];

  always @(posedge clk) begin
    if (slave_drv && oe) viol++;
    if (!slave_en || rst || gsel) begin
      beat = 0;
      slave_drv <= 1'b0;
    end else begin
      beat = beat + 1;
      case (beat)
        1: begin s_rd = grdwr; s_adr[15:8] = gad_out; end
        2: begin
          s_adr[7:0] = gad_out;
          if (s_rd) s_data = mem.exists(s_adr) ? mem[s_adr] : 32'h0;
        end
        3, 4, 5: if (!s_rd) s_wd = {s_wd[23:0], gad_out};
        6: if (!s_rd) mem[s_adr] = {s_wd[23:0], gad_out};
        default: ;
      endcase
      if (s_rd && beat >= 4 && beat <= 7) begin
        slave_drv <= 1'b1;
        slave_gad <= s_data[31:24];
        s_data = {s_data[23:0], 8'h00};
      end else begin
        slave_drv <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        rst, wr, rd;
    logic [15:0] adr;
    logic [31:0] wdat;
    logic [7:0]  gad;
    logic        sel, rdwr;
    logic [7:0]  ad;
    logic        oe, ack, busy;
    logic [31:0] dat;
  } vec_t;

  function automatic vec_t mk(input logic r, w, d, input logic [15:0] a,
                              input logic [31:0] wd, input logic [7:0] g,
                              input logic s, rw, input logic [7:0] ad,
                              input logic o, k, b, input logic [31:0] dd);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = d; v.adr = a; v.wdat = wd; v.gad = g;
    v.sel = s; v.rdwr = rw; v.ad = ad; v.oe = o; v.ack = k; v.busy = b; v.dat = dd;
    return v;
  endfunction

  task automatic txn(input logic w, input logic [15:0] a, input logic [31:0] d);
    wr = w; rd = ~w; adr = a; wdat = d;
    tick;
    wr = 1'b0; rd = 1'b0;
    for (int n = 0; n < 20 && !ack; n++) tick;
    if (!ack) check("txn_ack_timeout", 32'(ack), 32'd1);
    tick;
  endtask

  vec_t tbl[$];

  initial begin
    int acks, acks_early, last_low, first_low2, late_acks;
    logic [15:0] ra;
    logic [31:0] rdat;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; adr = '0; wdat = '0; tb_gad = 8'hA5;
    tick; tick;

    // Each row: inputs during cycle n, expected outputs in cycle n+1.
    tbl.push_back(mk(1,1,0,16'h0010,32'hDEADBEEF,8'hA5, 1,1,8'h00,0,0,0,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,1,8'h00,0,0,0,32'h0));
    tbl.push_back(mk(0,1,0,16'h0010,32'hDEADBEEF,8'hA5, 0,0,8'h00,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'h10,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'hDE,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'hAD,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'hBE,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'hEF,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,0,8'h00,0,1,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,1,8'h00,0,0,0,32'h0));
    tbl.push_back(mk(0,0,1,16'h0021,32'h0,8'hA5,        0,1,8'h00,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,1,8'h21,1,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,1,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,1,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,1,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'h12,        0,1,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'h34,        0,1,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'h56,        0,1,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'h78,        1,1,8'h00,0,1,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,1,8'h00,0,0,0,32'h12345678));
    tbl.push_back(mk(0,1,1,16'h0055,32'h01020304,8'hA5, 0,0,8'h00,1,0,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'h55,1,0,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'h01,1,0,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'h02,1,0,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'h03,1,0,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        0,0,8'h04,1,0,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,0,8'h00,0,1,1,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,1,8'h00,0,0,0,32'h12345678));
    tbl.push_back(mk(0,0,0,16'h0000,32'h0,8'hA5,        1,1,8'h00,0,0,0,32'h12345678));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; wr = tbl[i].wr; rd = tbl[i].rd;
      adr = tbl[i].adr; wdat = tbl[i].wdat; tb_gad = tbl[i].gad;
      tick;
      check($sformatf("row%0d_bus", i),
            32'({gsel, grdwr, gad_out, oe, ack, busy}),
            32'({tbl[i].sel, tbl[i].rdwr, tbl[i].ad, tbl[i].oe, tbl[i].ack, tbl[i].busy}));
      check($sformatf("row%0d_dat", i), dat_o, tbl[i].dat);
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0; tb_gad = 8'hA5;

    // Read with a stray request mid-transaction, then a fresh read in the first IDLE cycle.
    acks = 0; acks_early = 0; last_low = -1; first_low2 = -1;
    for (int c = 0; c <= 20; c++) begin
      rd  = (c == 0 || c == 4 || c == 10);
      adr = (c >= 10) ? 16'h0031 : 16'h0030;
      case (c)
        5: tb_gad = 8'hAA;  6: tb_gad = 8'hBB;  7: tb_gad = 8'hCC;  8: tb_gad = 8'hDD;
        15: tb_gad = 8'h11; 16: tb_gad = 8'h22; 17: tb_gad = 8'h33; 18: tb_gad = 8'h44;
        default: tb_gad = 8'hA5;
      endcase
      tick;
      if (ack) begin
        acks++;
        if (c + 1 <= 10) acks_early++;
      end
      if (!gsel && c + 1 <= 8) last_low = c + 1;
      if (!gsel && c + 1 >= 11 && first_low2 < 0) first_low2 = c + 1;
      if (c + 1 == 9) begin
        check("rd1_ack", 32'(ack), 32'd1);
        check("rd1_data", dat_o, 32'hAABBCCDD);
      end
      if (c + 1 == 11) check("rd2_a1", 32'({gsel, oe, grdwr, gad_out}), 32'({1'b0, 1'b1, 1'b1, 8'h00}));
      if (c + 1 == 12) check("rd2_a0", 32'(gad_out), 32'h31);
      if (c + 1 == 19) begin
        check("rd2_ack", 32'(ack), 32'd1);
        check("rd2_data", dat_o, 32'h11223344);
      end
    end
    rd = 1'b0; tb_gad = 8'hA5;
    check("drop_acks_early", 32'(acks_early), 32'd1);
    check("drop_acks_total", 32'(acks), 32'd2);
    check("gsel_gap", 32'((first_low2 - last_low - 1) >= 1), 32'd1);
    check("drop_idle_busy", 32'(busy), 32'd0);

    // Reset in cycle 5 of a read.
    adr = 16'h0044; rd = 1'b1;
    tick;
    rd = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    check("rst_mid_bus", 32'({gsel, grdwr, oe, busy, ack, gad_out}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    check("rst_mid_dat", dat_o, 32'h0);
    rst = 1'b0;
    late_acks = 0;
    repeat (12) begin
      tick;
      if (ack) late_acks++;
    end
    check("rst_no_ack", 32'(late_acks), 32'd0);
    check("rst_idle", 32'({busy, gsel}), 32'({1'b0, 1'b1}));

    // Random write-then-readback against the slave model.
    slave_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra   = 16'($urandom);
      rdat = $urandom;
      txn(1'b1, ra, rdat);
      txn(1'b0, ra, 32'h0);
      check($sformatf("rand%0d_%h", i, ra), dat_o, rdat);
    end
    check("oe_while_slave_drives", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
